sp1_arb4_rr: RTL and testbench

//  4-requester round-robin arbiter with registered one-hot grant.

---
 rtl/sp1_arb4_rr_pkg.sv | 13 +
 rtl/sp1_arb4_rr_pick4.sv | 43 ++++
 rtl/sp1_arb4_rr.sv | 106 ++++++++++
 tb/tb_sp1_arb4_rr.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/sp1_arb4_rr_pkg.sv
// Shared definitions for the 4-way round-robin arbiter slice.
// Contents: arbiter state encoding and requester count.
// Imported by sp1_arb4_rr and sp1_arb4_rr_pick4.
package sp1_arb4_rr_pkg;

   localparam int SP1_ARB_N = 4;

   typedef enum logic {
      SP1_ARB_IDLE = 1'b0,
      SP1_ARB_BUSY = 1'b1
   } arb_state_t;

endpackage

// File: rtl/sp1_arb4_rr_pick4.sv
// Round-robin winner search over 4 requesters: rotate, priority-encode, rotate back.
// Ports: req/mask (4b) and ptr (2b) in; pick (one-hot), pick_enc (index), any out.
// Purely combinational; masked-out requesters are never picked.
module sp1_arb4_rr_pick4
   import sp1_arb4_rr_pkg::*;
(
   input  logic [SP1_ARB_N-1:0] req,
   input  logic [1:0]           ptr,
   input  logic [SP1_ARB_N-1:0] mask,
   output logic [SP1_ARB_N-1:0] pick,
   output logic [1:0]           pick_enc,
   output logic                 any
);

   logic [SP1_ARB_N-1:0]   req_m;
   logic [2*SP1_ARB_N-1:0] req_dbl;
   logic [SP1_ARB_N-1:0]   rot;
   logic [1:0]             off;

   assign req_m   = req & ~mask;
   assign req_dbl = {req_m, req_m};
   // rot[k] is requester (ptr+k) mod 4, so rot[0] has highest priority
   assign rot     = req_dbl[ptr +: SP1_ARB_N];
   assign any     = |req_m;

   always_comb begin
      off = 2'd0;
      if (rot[0])      off = 2'd0;
      else if (rot[1]) off = 2'd1;
      else if (rot[2]) off = 2'd2;
      else if (rot[3]) off = 2'd3;
   end

   always_comb begin
      pick_enc = 2'd0;
      pick     = '0;
      if (any) begin
         pick_enc = ptr + off;
         pick     = SP1_ARB_N'(1) << pick_enc;
      end
   end

endmodule

// File: rtl/sp1_arb4_rr.sv
// 4-requester round-robin arbiter with registered one-hot grant (gnt), index (gnt_enc), valid.
// Ports: clk, rst (sync, active high), req[3:0] in; gnt[3:0], gnt_enc[1:0], gnt_vld out.
// Grant is registered one edge after req; define SP1_ARB_LOCK_EN to lock bursts up to HOLD_MAX.
module sp1_arb4_rr
   import sp1_arb4_rr_pkg::*;
#(
   parameter int HOLD_MAX = 16,
   parameter int CW       = 8
)
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [SP1_ARB_N-1:0] req,
   output logic [SP1_ARB_N-1:0] gnt,
   output logic [1:0]           gnt_enc,
   output logic                 gnt_vld
);

   arb_state_t           state;
   logic [1:0]           ptr;
   logic [SP1_ARB_N-1:0] mask;
   logic [SP1_ARB_N-1:0] pick;
   logic [1:0]           pick_enc;
   logic                 pick_any;
   logic                 release_now;

   // While busy the current holder is excluded so a competing request wins first
   assign mask = (state == SP1_ARB_BUSY) ? gnt : '0;

   sp1_arb4_rr_pick4 u_pick (
      .req      (req),
      .ptr      (ptr),
      .mask     (mask),
      .pick     (pick),
      .pick_enc (pick_enc),
      .any      (pick_any)
   );

`ifdef SP1_ARB_LOCK_EN
   logic [CW-1:0] hold_cnt;
   logic          hold_full;

   assign hold_full   = (hold_cnt == CW'(HOLD_MAX));
   assign release_now = ~req[gnt_enc] | hold_full;
`else
   // Without locking the hold limit has no effect; every busy cycle re-arbitrates
   localparam int unused_cfg = HOLD_MAX + CW;
   assign release_now = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= SP1_ARB_IDLE;
         ptr     <= '0;
         gnt     <= '0;
         gnt_enc <= '0;
         gnt_vld <= 1'b0;
`ifdef SP1_ARB_LOCK_EN
         hold_cnt <= '0;
`endif
      end else begin
         unique case (state)
            SP1_ARB_IDLE: begin
               if (pick_any) begin
                  state   <= SP1_ARB_BUSY;
                  gnt     <= pick;
                  gnt_enc <= pick_enc;
                  gnt_vld <= 1'b1;
                  ptr     <= pick_enc + 2'd1;
`ifdef SP1_ARB_LOCK_EN
                  hold_cnt <= CW'(1);
`endif
               end
            end
            SP1_ARB_BUSY: begin
               if (release_now) begin
                  if (pick_any) begin
                     gnt     <= pick;
                     gnt_enc <= pick_enc;
                     ptr     <= pick_enc + 2'd1;
`ifdef SP1_ARB_LOCK_EN
                     hold_cnt <= CW'(1);
`endif
                  end else if (req[gnt_enc]) begin
                     // Sole requester re-granted; ptr already points past it
`ifdef SP1_ARB_LOCK_EN
                     hold_cnt <= CW'(1);
`endif
                  end else begin
                     state   <= SP1_ARB_IDLE;
                     gnt     <= '0;
                     gnt_enc <= '0;
                     gnt_vld <= 1'b0;
                  end
               end
`ifdef SP1_ARB_LOCK_EN
               else if (!hold_full) begin
                  hold_cnt <= hold_cnt + CW'(1);
               end
`endif
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sp1_arb4_rr.sv
module tb_sp1_arb4_rr;

   localparam int HM = 4;
`ifdef SP1_ARB_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = 4'b0000;
   logic [3:0] gnt;
   logic [1:0] gnt_enc;
   logic       gnt_vld;

   int n_vec = 0;
   int n_mis = 0;

   // behavioural model: holder index (-1 = none), pointer, hold count
   int m_idx = -1;
   int m_ptr = 0;
   int m_hold = 0;
   bit started = 1'b0;

   logic [7:0] a [4];

   always #5 clk = ~clk;

   sp1_arb4_rr #(.HOLD_MAX(HM), .CW(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .gnt     (gnt),
      .gnt_enc (gnt_enc),
      .gnt_vld (gnt_vld)
   );

   // first requester found scanning p, p+1, .. mod 4, skipping index ex
   function automatic int find(input logic [3:0] r, input int p, input int ex);
      for (int k = 0; k < 4; k++) begin
         int j;
         j = (p + k) % 4;
         if (j != ex && r[j]) return j;
      end
      return -1;
   endfunction

   always @(posedge clk) begin
      int w;
      bit rel;
      if (rst) begin
         m_idx = -1; m_ptr = 0; m_hold = 0;
      end else if (m_idx < 0) begin
         w = find(req, m_ptr, -1);
         if (w >= 0) begin m_idx = w; m_ptr = (w + 1) % 4; m_hold = 1; end
      end else begin
         rel = LOCK ? (!req[m_idx] || m_hold == HM) : 1'b1;
         if (rel) begin
            w = find(req, m_ptr, m_idx);
            if (w >= 0) begin m_idx = w; m_ptr = (w + 1) % 4; m_hold = 1; end
            else if (req[m_idx]) m_hold = 1;
            else m_idx = -1;
         end else if (m_hold < HM) begin
            m_hold = m_hold + 1;
         end
      end
      started = 1'b1;
   end

   // per-cycle comparison against the model plus structural invariants
   always @(negedge clk) begin
      logic [3:0] eg;
      logic [1:0] ee;
      logic [3:0] oh;
      logic [7:0] y_sel, y_oh;
      if (started) begin
         eg = (m_idx < 0) ? 4'b0000 : 4'(1 << m_idx);
         ee = (m_idx < 0) ? 2'd0 : 2'(m_idx);
         n_vec++;
         if (gnt !== eg || gnt_enc !== ee || gnt_vld !== (m_idx >= 0)) begin
            n_mis++;
            $display("FAIL model t=%0t gnt=%b enc=%0d vld=%b required gnt=%b enc=%0d vld=%b",
                     $time, gnt, gnt_enc, gnt_vld, eg, ee, (m_idx >= 0));
         end
         oh = gnt_vld ? 4'(1 << gnt_enc) : 4'b0000;
         n_vec++;
         if (gnt !== oh || gnt_vld !== (|gnt) || (!gnt_vld && gnt_enc !== 2'd0)) begin
            n_mis++;
            $display("FAIL onehot t=%0t gnt=%b enc=%0d vld=%b", $time, gnt, gnt_enc, gnt_vld);
         end
         y_sel = gnt_vld ? a[gnt_enc] : 8'h00;
         y_oh  = 8'h00;
         for (int i = 0; i < 4; i++) if (gnt[i]) y_oh = y_oh | a[i];
         n_vec++;
         if (y_oh !== y_sel) begin
            n_mis++;
            $display("FAIL mux t=%0t y=%h required %h", $time, y_oh, y_sel);
         end
      end
   end

   task automatic cyc(input logic [3:0] r, input logic rs);
      req = r;
      rst = rs;
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [3:0] eg, input logic ev);
      n_vec++;
      if (gnt !== eg || gnt_vld !== ev) begin
         n_mis++;
         $display("FAIL %s gnt=%b vld=%b required gnt=%b vld=%b", nm, gnt, gnt_vld, eg, ev);
      end
   endtask

   logic [3:0] exp_b [7];
   logic [3:0] exp_c [9];
   logic [3:0] tail  [16];

   initial begin
      a[0] = 8'h11; a[1] = 8'h22; a[2] = 8'h44; a[3] = 8'h88;
`ifdef SP1_ARB_LOCK_EN
      exp_b = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0010};
      exp_c = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
`else
      exp_b = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
      exp_c = '{4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001, 4'b0100, 4'b0001};
`endif
      tail = '{4'b1010, 4'b1010, 4'b0110, 4'b1111, 4'b0000, 4'b1001, 4'b1001, 4'b1100,
               4'b0011, 4'b0001, 4'b1110, 4'b0111, 4'b1000, 4'b1011, 4'b0000, 4'b0101};

      @(negedge clk);
      // reset held with all requesting
      for (int i = 0; i < 5; i++) begin
         cyc(4'b1111, 1'b1);
         chk("reset_hold", 4'b0000, 1'b0);
      end
      cyc(4'b1111, 1'b0);
      chk("first_after_reset", 4'b0001, 1'b1);
      // all four requesting
      for (int i = 0; i < 7; i++) begin
         cyc(4'b1111, 1'b0);
         chk("all_req_rotate", exp_b[i], 1'b1);
      end
      // two masters 0 and 2
      cyc(4'b0000, 1'b1);
      chk("reset_mid_grant", 4'b0000, 1'b0);
      for (int i = 0; i < 9; i++) begin
         cyc(4'b0101, 1'b0);
         chk("pair_0101", exp_c[i], 1'b1);
      end
      // holder drops while another raises: zero-bubble handover
      cyc(4'b0000, 1'b1);
      cyc(4'b0001, 1'b0);
      chk("handover_pre", 4'b0001, 1'b1);
      cyc(4'b1000, 1'b0);
      chk("handover_0_to_3", 4'b1000, 1'b1);
      cyc(4'b0000, 1'b0);
      chk("release_to_idle", 4'b0000, 1'b0);
      // single master held continuously, then released
      for (int i = 0; i < 7; i++) begin
         cyc(4'b0010, 1'b0);
         chk("single_master", 4'b0010, 1'b1);
      end
      cyc(4'b0000, 1'b0);
      chk("single_release", 4'b0000, 1'b0);
      // reset pulse mid-grant, pointer returns to 0
      cyc(4'b0100, 1'b0);
      chk("grant_2", 4'b0100, 1'b1);
      cyc(4'b0100, 1'b1);
      chk("rst_pulse_a", 4'b0000, 1'b0);
      cyc(4'b0110, 1'b0);
      chk("ptr_reset_a", 4'b0010, 1'b1);
      cyc(4'b0000, 1'b0);
      cyc(4'b0010, 1'b0);
      chk("grant_1", 4'b0010, 1'b1);
      cyc(4'b0010, 1'b1);
      chk("rst_pulse_b", 4'b0000, 1'b0);
      cyc(4'b0110, 1'b0);
      chk("ptr_reset_b", 4'b0010, 1'b1);
      // mixed directed sequence, checked by the model only
      for (int i = 0; i < 16; i++) cyc(tail[i], 1'b0);
      cyc(4'b0000, 1'b0);
      cyc(4'b0000, 1'b0);
      chk("final_idle", 4'b0000, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
